synchroniser_debounce: RTL



---
 rtl/synchroniser_debounce_channel.sv | 74 +++++++
 rtl/synchroniser_debounce.sv | 38 +++
 2 files changed

// File: rtl/synchroniser_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One channel of the board-input conditioner. It synchronises the
//            input, debounces it with a stability counter and emits rise/fall
//            pulses.
// Revision : 1.0
// ============================================================================
module debounce_channel #(
    parameter int   STAGES          = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic x_i,
    output logic y_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);

    logic [STAGES-1:0] sync_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              y_q, y_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              w_s;

    // Last synchroniser stage is the only view of x used downstream.
    assign w_s = sync_q[STAGES-1];

    always_comb begin
        cnt_d  = cnt_q;
        y_d    = y_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (w_s == y_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
            y_d    = w_s;
            cnt_d  = '0;
            rise_d = w_s;
            fall_d = ~w_s;
        end else begin
            cnt_d = cnt_q + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_BIT}};
            cnt_q  <= '0;
            y_q    <= RESET_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], x_i};
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign y_o    = y_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/synchroniser_debounce.sv
`default_nettype none
// ============================================================================
// Module   : synchroniser_debounce
// Purpose  : WIDTH independent synchronise + debounce channels with one-cycle
//            rise/fall pulses, all outputs registered.
// Revision : 1.0
// ============================================================================
module synchroniser_debounce #(
    parameter int               WIDTH           = 4,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        debounce_channel #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[gi])
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .x_i    (x[gi]),
            .y_o    (y[gi]),
            .rise_o (rise[gi]),
            .fall_o (fall[gi])
        );
    end

endmodule
`default_nettype wire
